// File: rtl/tx_udp.sv
// UDP transmit framer: emits an 8-byte UDP header then a payload stream pulled
// from a synchronous-read buffer. Checksum is sent as zero.
module tx_udp #(
  parameter int OCT     = 8,
  parameter int MAX_LEN = 1472
) (
  input  logic            RX_CLK,
  input  logic            rst,
  input  logic            func_en,
  input  logic            tx_start,
  input  logic [15:0]     tx_src_port,
  input  logic [15:0]     tx_dst_port,
  input  logic [15:0]     tx_len,
  output logic            tx_busy,
  output logic            tx_err,
  output logic            tx_payload_rd,
  input  logic [OCT-1:0]  tx_payload,
  output logic [15:0]     tx_udp_len,
  output logic            tx_udp_data_v,
  output logic [OCT-1:0]  tx_udp_data,
  output logic            tx_udp_done
);

  // state | meaning
  // IDLE  | waiting for an accepted request
  // HDR   | header bytes 0..7
  // DATA  | payload bytes 0..len-1
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

  state_t         state_q, state_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [15:0]    src_q, dst_q, len_q;
  logic [OCT-1:0] pay_q, last_q, hdr_byte;
  logic           err_q;
  logic           req, accept, reject;

  assign req    = (state_q == IDLE) && tx_start && func_en;
  assign accept = req && (tx_len <= 16'(MAX_LEN));
  assign reject = req && (tx_len >  16'(MAX_LEN));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = HDR;
        cnt_d   = '0;
      end
      HDR: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'd7) begin
          cnt_d   = '0;
          state_d = (len_q == 16'd0) ? DONE : DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == len_q - 16'd1) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      tx_udp_len <= '0;
      err_q      <= 1'b0;
      pay_q      <= '0;
      last_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= reject;
      pay_q   <= tx_payload;
      if (tx_udp_data_v) last_q <= tx_udp_data;
      if (accept) begin
        src_q      <= tx_src_port;
        dst_q      <= tx_dst_port;
        len_q      <= tx_len;
        tx_udp_len <= tx_len + 16'd8;
      end
    end
  end

  always_comb begin
    case (cnt_q[2:0])
      3'd0:    hdr_byte = src_q[15:8];
      3'd1:    hdr_byte = src_q[7:0];
      3'd2:    hdr_byte = dst_q[15:8];
      3'd3:    hdr_byte = dst_q[7:0];
      3'd4:    hdr_byte = tx_udp_len[15:8];
      3'd5:    hdr_byte = tx_udp_len[7:0];
      default: hdr_byte = '0;
    endcase
  end

  // Reads run two cycles ahead of the output: buffer latency plus pay_q.
  always_comb begin
    tx_payload_rd = 1'b0;
    if (state_q == HDR)
      tx_payload_rd = (cnt_q[2:0] == 3'd6 && len_q > 16'd0) ||
                      (cnt_q[2:0] == 3'd7 && len_q > 16'd1);
    else if (state_q == DATA)
      tx_payload_rd = ({1'b0, cnt_q} + 17'd2) < {1'b0, len_q};
  end

  assign tx_busy       = (state_q == HDR) || (state_q == DATA);
  assign tx_udp_data_v = tx_busy;
  assign tx_udp_done   = (state_q == DONE);
  assign tx_err        = err_q;
  assign tx_udp_data   = (state_q == HDR)  ? hdr_byte :
                         (state_q == DATA) ? pay_q    : last_q;

endmodule

// File: doc/tx_udp.md
# tx_udp

UDP transmit framer: on a start pulse, emits an 8-byte UDP header followed by a payload byte stream toward the IPv4 transmit layer. Payload is pulled from an upstream synchronous-read buffer through a read-strobe interface. Header fields come from per-frame port inputs. The checksum is transmitted as 0x0000 (checksum disabled, legal for IPv4). The block is the transmit counterpart of the UDP receive parser and sits between the application payload buffer and the IPv4 TX framer.

## Interface
- OCT, 8, bits per byte
- MAX_LEN, 1472, largest accepted payload length in bytes
- RX_CLK  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- func_en  in  1  enables acceptance of new frames; an in-flight frame always completes
- tx_start  in  1  single-cycle frame request
- tx_src_port  in  16  UDP source port, sampled with tx_start
- tx_dst_port  in  16  UDP destination port, sampled with tx_start
- tx_len  in  16  payload length in bytes, sampled with tx_start
- tx_busy  out  1  frame in progress
- tx_err  out  1  one-cycle pulse: request rejected (tx_len > MAX_LEN)
- tx_payload_rd  out  1  read strobe to payload buffer
- tx_payload  in  OCT  payload byte, valid the cycle after tx_payload_rd
- tx_udp_len  out  16  UDP length (tx_len+8), latched at accept, held until next accept
- tx_udp_data_v  out  1  output byte valid
- tx_udp_data  out  OCT  output byte
- tx_udp_done  out  1  one-cycle pulse after the last byte

## Operation
- FSM states:
  - IDLE: accepts a request when tx_start & func_en & tx_len<=MAX_LEN. Latches ports and length, then goes to HDR.
  - HDR: 8 bytes, byte counter 0..7.
  - DATA: tx_len bytes, byte counter 0..tx_len-1.
  - DONE: 1 cycle, pulses tx_udp_done, then returns to IDLE.
- If tx_len==0, HDR goes directly to DONE.
- Header byte order, MSB first: src_port[15:8], src_port[7:0], dst_port[15:8], dst_port[7:0], len[15:8], len[7:0], 0x00, 0x00.
- Length field = tx_len + 8, computed in 16 bits. No overflow is possible because tx_len<=MAX_LEN.
- tx_start & func_en & tx_len>MAX_LEN in IDLE: pulse tx_err next cycle, stay IDLE, no output, tx_udp_len unchanged.
- tx_start outside IDLE: ignored; no error, latched fields unchanged.
- tx_start with func_en low: ignored.
- func_en falling mid-frame: no effect; frame completes.
- Payload bytes are forwarded unmodified, in read order. There is no backpressure from the IPv4 layer; the stream is gap-free.

## Timing
- Cycle 0 = cycle in which the accepted tx_start is high.
- tx_busy: high cycles 1 through 8+L, where L=tx_len; low in DONE and IDLE.
- Header: tx_udp_data_v=1 with header bytes 0..7 in cycles 1..8.
- tx_payload_rd: high cycles 7..6+L, exactly L strobes; never asserted when L=0.
- Payload: byte captured from tx_payload in cycle k+1 appears on tx_udp_data in cycle k+2. Payload bytes occupy cycles 9..8+L with data_v=1.
- tx_udp_done: high in cycle 9+L, data_v=0.
- Earliest next accept: tx_start in cycle 10+L, since the block is in IDLE from cycle 10+L.
- Back-to-back frames are therefore separated by 2 idle output cycles.
- tx_udp_data when data_v=0: holds its last value; don't-care for consumers.
- Reset values (next edge after rst=1): state IDLE, tx_busy=0, tx_err=0, tx_payload_rd=0, tx_udp_data_v=0, tx_udp_data=0, tx_udp_done=0, tx_udp_len=0, counters 0.
- Reset mid-frame: aborts immediately with the values above. No done pulse. Remaining payload reads are not issued. The upstream buffer is responsible for its own flush.

## Test plan
- Payload of 4 bytes: src=0x1234, dst=0x0050, tx_len=4, payload AA BB CC DD.
  - Cycles 1..12 output 12 34 00 50 00 0C 00 00 AA BB CC DD.
  - rd high cycles 7..10.
  - done at cycle 13; tx_udp_len=0x000C.
- Zero-length frame: tx_len=0.
  - Header with length 0x0008 in cycles 1..8.
  - No rd; done at cycle 9; busy cycles 1..8.
- Oversize request: tx_len=1473.
  - tx_err pulse in cycle 1.
  - No data_v, no rd, busy stays 0.
  - A following valid request is accepted normally.
- Busy/disabled requests: tx_start pulsed mid-frame (cycle 5), and tx_start with func_en=0.
  - Both ignored; in-flight output is byte-exact.
  - func_en dropped at cycle 3 still completes the frame.
- Reset mid-frame: rst at cycle 10 of a tx_len=4 frame.
  - Next cycle all outputs 0.
  - No done; no further rd.
  - A new request afterwards produces a correct frame.
- Back-to-back maximum-length frames: two frames of tx_len=1472 with tx_start at cycle 0 and cycle 1482.
  - Both frames byte-exact.
  - Second header starts at cycle 1483.
  - Exactly 1472 rd strobes per frame.
